// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - size encodings, FSM states and lane helpers for data_mem_ctrl
package dmem_pkg;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_RSV = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } dmem_state_t;

    // Select the addressed byte/half from a read word and extend it to 32 bits.
    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_B:    lane_extract = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    lane_extract = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: lane_extract = word;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(
        input logic [1:0] off,
        input logic [1:0] size
    );
        case (size)
            SZ_B:    byte_en = 4'b0001 << off;
            SZ_H:    byte_en = 4'b0011 << off;
            default: byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// rtl/dmem_bram.sv - single-port byte-enable RAM with registered read
module dmem_bram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Read-first; the controller only uses rdata for cycles that were loads.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we && be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-addressable data memory controller; optional DMEM_ERR_CHECK_EN
import dmem_pkg::*;

module data_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    input  logic                  clr_start,
    output logic                  clr_busy
);

    localparam int N_WORDS = 2 ** ADDR_WIDTH;

    dmem_state_t           state;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    logic                  accept;
    logic                  err;
    logic                  in_clear;
    logic [1:0]            eff_sz;
    logic [1:0]            eff_off;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           wdata_rep;

    logic                  ram_we;
    logic [3:0]            ram_be;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    logic                  rsp_ld;
    logic                  rsp_uns;
    logic [1:0]            rsp_off;
    logic [1:0]            rsp_sz;

    assign in_clear  = (state == CLEAR);
    assign clr_busy  = in_clear;
    assign req_ready = ~rst & (state == IDLE) & ~clr_start;
    assign accept    = req_valid & req_ready;
    assign word_idx  = req_addr[ADDR_WIDTH+1:2];

`ifdef DMEM_ERR_CHECK_EN
    always_comb begin
        eff_sz  = req_size;
        eff_off = req_addr[1:0];
        err     = (req_size == SZ_RSV)
                | ((req_size == SZ_H) & req_addr[0])
                | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00))
                | (req_addr[31:ADDR_WIDTH+2] != '0);
    end
`else
    // Upper address bits are dropped: out-of-range accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    always_comb begin
        eff_sz = (req_size == SZ_RSV) ? SZ_W : req_size;
        case (eff_sz)
            SZ_H:    eff_off = {req_addr[1], 1'b0};
            SZ_W:    eff_off = 2'b00;
            default: eff_off = req_addr[1:0];
        endcase
        err = 1'b0;
    end
`endif

    always_comb begin
        case (eff_sz)
            SZ_B:    wdata_rep = {4{req_wdata[7:0]}};
            SZ_H:    wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata[31:0];
        endcase
    end

    // The clear sequencer owns the RAM port; requests are blocked meanwhile.
    always_comb begin
        ram_we    = in_clear | (accept & req_we & ~err);
        ram_addr  = in_clear ? clr_cnt : word_idx;
        ram_be    = in_clear ? 4'b1111 : byte_en(eff_off, eff_sz);
        ram_wdata = in_clear ? 32'b0 : wdata_rep;
    end

    dmem_bram #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_ld    <= 1'b0;
            rsp_uns   <= 1'b0;
            rsp_off   <= 2'b00;
            rsp_sz    <= SZ_B;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept & err;
            rsp_ld    <= accept & ~req_we & ~err;
            if (accept) begin
                rsp_uns <= req_unsigned;
                rsp_off <= eff_off;
                rsp_sz  <= eff_sz;
            end
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_WIDTH'(N_WORDS - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stores and errors return zero; loads are extracted from the fresh read.
    assign rsp_rdata = rsp_ld ? DATA_WIDTH'(lane_extract(ram_rdata, rsp_off, rsp_sz, rsp_uns))
                              : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - randomized self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

    localparam int AW        = 4;
    localparam int MEM_BYTES = 4 << AW;
    localparam int N_WORDS   = 1 << AW;
`ifdef DMEM_ERR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        clr_start;
    logic        clr_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] bmem [0:MEM_BYTES-1];

    data_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .clr_start    (clr_start),
        .clr_busy     (clr_busy)
    );

    always #5 clk = ~clk;

    // Byte-level memory model: a request touches n consecutive bytes.
    function automatic void model(input req_t r, output logic [31:0] rd, output logic err);
        int n;
        int a;
        logic [31:0] v;
        rd  = 32'h0;
        err = 1'b0;
        if (CHK) begin
            err = (r.sz == 2'd3) || (r.sz == 2'd1 && r.addr % 2 != 0) ||
                  (r.sz == 2'd2 && r.addr % 4 != 0) || (r.addr >= 32'(MEM_BYTES));
        end
        if (err) return;
        n = (r.sz == 2'd0) ? 1 : (r.sz == 2'd1) ? 2 : 4;
        a = int'(r.addr % 32'(MEM_BYTES));
        a = a - (a % n);
        if (r.we) begin
            for (int k = 0; k < n; k++) bmem[a + k] = r.wdata[8*k +: 8];
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = bmem[a + k];
            if (!r.uns && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < MEM_BYTES; k++) bmem[k] = 8'h00;
    endfunction

    function automatic req_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.sz = sz; r.uns = uns; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    // Drives one cycle; reports ready before the edge and the response after it.
    task automatic run_req(input logic v, input req_t r, output logic rdy, output logic ov,
                           output logic oe, output logic [31:0] od);
        req_valid    = v;
        req_we       = r.we;
        req_size     = r.sz;
        req_unsigned = r.uns;
        req_addr     = r.addr;
        req_wdata    = r.wdata;
        #1;
        rdy = req_ready;
        @(posedge clk);
        #1;
        ov = rsp_valid;
        oe = rsp_err;
        od = rsp_rdata;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; clr_start = 1'b0;
        #2;
        total++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
            rsp_rdata !== 32'h0 || clr_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: ready=%b valid=%b err=%b rdata=%h busy=%b want 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata, clr_busy);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || clr_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b valid=%b busy=%b want 1 0 0",
                     req_ready, rsp_valid, clr_busy);
        end
    endtask

    task automatic test_clear(input bit hold_req);
        int busy;
        int ready_bad;
        int valid_bad;
        clr_start = 1'b1;
        if (hold_req) begin
            req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
            req_addr = 32'h10; req_wdata = 32'h0;
        end
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL clear_start_ready: got %b want 0", req_ready);
        end
        @(posedge clk);
        #1 clr_start = 1'b0;
        busy = 0; ready_bad = 0; valid_bad = 0;
        for (int c = 0; c < 100 && clr_busy === 1'b1; c++) begin
            busy++;
            if (req_ready !== 1'b0) ready_bad++;
            if (rsp_valid !== 1'b0) valid_bad++;
            @(posedge clk);
            #1;
        end
        model_clear();
        total++;
        if (busy != N_WORDS || ready_bad != 0 || valid_bad != 0) begin
            bad++;
            $display("FAIL clear_busy: busy_cycles=%0d ready_high=%0d rsp_during=%0d want %0d 0 0",
                     busy, ready_bad, valid_bad, N_WORDS);
        end
        if (hold_req) begin
            total++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL clear_held_ready: ready=%b valid=%b want 1 0", req_ready, rsp_valid);
            end
            @(posedge clk);
            #1 req_valid = 1'b0;
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
                bad++;
                $display("FAIL clear_held_rsp: valid=%b rdata=%h err=%b want 1 00000000 0",
                         rsp_valid, rsp_rdata, rsp_err);
            end
        end
    endtask

    task automatic test_store_load();
        req_t q[$];
        logic rdy, ov, oe, ee;
        logic [31:0] od, ed;
        q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF));
        q.push_back(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0));
        q.push_back(mk(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080));
        q.push_back(mk(1'b0, 2'd0, 1'b0, 32'h13, 32'h0));
        q.push_back(mk(1'b0, 2'd0, 1'b1, 32'h13, 32'h0));
        q.push_back(mk(1'b0, 2'd1, 1'b0, 32'h12, 32'h0));
        q.push_back(mk(1'b0, 2'd1, 1'b1, 32'h12, 32'h0));
        q.push_back(mk(1'b1, 2'd1, 1'b0, 32'h16, 32'hFFFF_8001));
        q.push_back(mk(1'b0, 2'd2, 1'b1, 32'h14, 32'h0));
        foreach (q[i]) begin
            model(q[i], ed, ee);
            run_req(1'b1, q[i], rdy, ov, oe, od);
            total++;
            if (rdy !== 1'b1 || ov !== 1'b1 || od !== ed || oe !== ee) begin
                bad++;
                $display("FAIL store_load[%0d]: rdy=%b valid=%b rdata=%h err=%b want 1 1 %h %b",
                         i, rdy, ov, od, oe, ed, ee);
            end
        end
    endtask

    task automatic test_errors();
        req_t q[$];
        logic rdy, ov, oe, ee;
        logic [31:0] od, ed;
        q.push_back(mk(1'b0, 2'd1, 1'b0, 32'h11, 32'h0));
        q.push_back(mk(1'b0, 2'd2, 1'b0, 32'h12, 32'h0));
        q.push_back(mk(1'b1, 2'd2, 1'b0, 32'(4 << AW), 32'h55AA_55AA));
        q.push_back(mk(1'b1, 2'd1, 1'b0, 32'h13, 32'h0000_1234));
        q.push_back(mk(1'b0, 2'd3, 1'b0, 32'h10, 32'h0));
        q.push_back(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0));
        q.push_back(mk(1'b0, 2'd2, 1'b0, 32'h00, 32'h0));
        foreach (q[i]) begin
            model(q[i], ed, ee);
            run_req(1'b1, q[i], rdy, ov, oe, od);
            total++;
            if (rdy !== 1'b1 || ov !== 1'b1 || od !== ed || oe !== ee) begin
                bad++;
                $display("FAIL errors[%0d]: rdy=%b valid=%b rdata=%h err=%b want 1 1 %h %b",
                         i, rdy, ov, od, oe, ed, ee);
            end
        end
    endtask

    task automatic test_back_to_back();
        req_t q[$];
        logic rdy, ov, oe, ee;
        logic [31:0] od, ed;
        q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344));
        q.push_back(mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0));
        q.push_back(mk(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00A5));
        q.push_back(mk(1'b0, 2'd1, 1'b0, 32'h20, 32'h0));
        q.push_back(mk(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_7E01));
        q.push_back(mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0));
        foreach (q[i]) begin
            model(q[i], ed, ee);
            run_req(1'b1, q[i], rdy, ov, oe, od);
            total++;
            if (rdy !== 1'b1 || ov !== 1'b1 || od !== ed || oe !== ee) begin
                bad++;
                $display("FAIL b2b[%0d]: rdy=%b valid=%b rdata=%h err=%b want 1 1 %h %b",
                         i, rdy, ov, od, oe, ed, ee);
            end
        end
    endtask

    task automatic test_random();
        req_t r;
        logic v, rdy, ov, oe, ee;
        logic [31:0] od, ed;
        for (int i = 0; i < 400; i++) begin
            v       = ($urandom_range(0, 7) != 0);
            r.we    = 1'($urandom_range(0, 1));
            r.sz    = 2'($urandom_range(0, 3));
            r.uns   = 1'($urandom_range(0, 1));
            r.addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES - 1));
            r.wdata = $urandom;
            ed = 32'h0; ee = 1'b0;
            if (v) model(r, ed, ee);
            run_req(v, r, rdy, ov, oe, od);
            total++;
            if (v) begin
                if (rdy !== 1'b1 || ov !== 1'b1 || od !== ed || oe !== ee) begin
                    bad++;
                    $display("FAIL random[%0d] we=%b sz=%0d u=%b a=%h: rdy=%b valid=%b rdata=%h err=%b want 1 1 %h %b",
                             i, r.we, r.sz, r.uns, r.addr, rdy, ov, od, oe, ed, ee);
                end
            end else if (rdy !== 1'b1 || ov !== 1'b0 || od !== 32'h0) begin
                bad++;
                $display("FAIL random_idle[%0d]: rdy=%b valid=%b rdata=%h want 1 0 00000000",
                         i, rdy, ov, od);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic rdy, ov, oe;
        logic [31:0] od;
        clr_start = 1'b1;
        @(posedge clk);
        #1 clr_start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if (clr_busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL midclear_rst: busy=%b valid=%b ready=%b want 0 0 0",
                     clr_busy, rsp_valid, req_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++;
        if (clr_busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL midclear_release: busy=%b valid=%b ready=%b want 0 0 1",
                     clr_busy, rsp_valid, req_ready);
        end
        test_clear(1'b0);
        for (int w = 0; w < N_WORDS; w++) begin
            run_req(1'b1, mk(1'b0, 2'd2, 1'b0, 32'(4 * w), 32'h0), rdy, ov, oe, od);
            total++;
            if (rdy !== 1'b1 || ov !== 1'b1 || od !== 32'h0 || oe !== 1'b0) begin
                bad++;
                $display("FAIL post_clear[%0d]: rdy=%b valid=%b rdata=%h err=%b want 1 1 00000000 0",
                         w, rdy, ov, od, oe);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear(1'b0);
        test_store_load();
        test_errors();
        test_back_to_back();
        test_random();
        test_clear(1'b1);
        test_random();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
